// File: rtl/handwrite_pkg.sv
// Shared types and defaults for the handwriting-canvas streamer.
package handwrite_pkg;

    localparam int CANVAS_W_DEF = 30;
    localparam int OUT_W_DEF    = 28;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CALC,
        STREAM
    } state_t;

    // Re-centring offset, range -14..+15
    typedef logic signed [5:0] offset_t;
    // Canvas / output coordinate, 0..29
    typedef logic        [4:0] coord_t;
    // Source coordinate after adding an offset, checked before use
    typedef logic signed [6:0] scoord_t;

endpackage

// File: rtl/bbox_finder.sv
// Lowest and highest set index of an occupancy vector, plus an empty flag.
module bbox_finder
    import handwrite_pkg::*;
#(
    parameter int W = CANVAS_W_DEF
) (
    input  logic [W-1:0] occ,
    output coord_t       min_idx,
    output coord_t       max_idx,
    output logic         empty
);

    // Two priority encoders: the last assignment in each loop wins
    always_comb begin
        min_idx = '0;
        max_idx = '0;
        empty   = (occ == '0);
        for (int i = W - 1; i >= 0; i--) begin
            if (occ[i]) min_idx = coord_t'(i);
        end
        for (int i = 0; i < W; i++) begin
            if (occ[i]) max_idx = coord_t'(i);
        end
    end

endmodule

// File: rtl/handwrite_streamer.sv
// Snapshots the canvas, re-centres the ink and streams a row-major
// OUT_W x OUT_W 8-bit image to the CNN.
//
// state  | meaning
// IDLE   | waiting for i_start; canvas captured on the start cycle
// SCAN   | one canvas row per cycle builds row/column occupancy
// CALC   | offsets from the bounding box; also emits pixel 0
// STREAM | emits remaining pixels, GAP idle cycles between them;
//        | after the last pixel one more cycle issues o_done
module handwrite_streamer
    import handwrite_pkg::*;
#(
    parameter int         CANVAS_W = CANVAS_W_DEF,
    parameter int         OUT_W    = OUT_W_DEF,
    parameter logic [7:0] PIXEL_ON = 8'd255,
    parameter int         GAP      = 0,
    parameter bit         CENTER   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CANVAS_W*CANVAS_W-1:0]   i_handwrite,
    input  logic                           i_start,
    output logic [7:0]                     pixel_o,
    output logic                           pixel_o_valid,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int      NBITS    = CANVAS_W * CANVAS_W;
    localparam int      AW       = $clog2(NBITS);
    localparam coord_t  LAST_ROW = coord_t'(CANVAS_W - 1);
    localparam coord_t  LAST_OUT = coord_t'(OUT_W - 1);
    localparam offset_t HALF     = offset_t'(OUT_W / 2);
    localparam offset_t FIXED    = offset_t'(1);
    localparam scoord_t CW_S     = scoord_t'(CANVAS_W);
    localparam logic [3:0] GAP_V = 4'(GAP);

    state_t              state_q, state_d;
    logic [NBITS-1:0]    snap_q, snap_d;
    logic [CANVAS_W-1:0] rowocc_q, rowocc_d;
    logic [CANVAS_W-1:0] colocc_q, colocc_d;
    coord_t              row_q, row_d;
    offset_t             sr_q, sr_d, sc_q, sc_d;
    coord_t              r_q, r_d, c_q, c_d;
    logic [3:0]          gap_q, gap_d;
    logic                last_q, last_d;
    logic [7:0]          pix_d;
    logic                valid_d, busy_d, done_d;
    logic                emit;

    logic [CANVAS_W-1:0] row_bits;
    coord_t              min_r, max_r, min_c, max_c;
    logic                row_empty, col_empty;
    coord_t              cen_r, cen_c;
    offset_t             calc_sr, calc_sc;
    offset_t             off_r, off_c;
    scoord_t             sy, sx;
    logic                in_bounds;
    logic [AW-1:0]       src_idx;
    logic                hit;

    assign row_bits = snap_q[int'(row_q) * CANVAS_W +: CANVAS_W];

    bbox_finder #(.W(CANVAS_W)) u_rows (
        .occ     (rowocc_q),
        .min_idx (min_r),
        .max_idx (max_r),
        .empty   (row_empty)
    );

    bbox_finder #(.W(CANVAS_W)) u_cols (
        .occ     (colocc_q),
        .min_idx (min_c),
        .max_idx (max_c),
        .empty   (col_empty)
    );

    assign cen_r   = coord_t'(({1'b0, min_r} + {1'b0, max_r}) >> 1);
    assign cen_c   = coord_t'(({1'b0, min_c} + {1'b0, max_c}) >> 1);
    assign calc_sr = (row_empty | col_empty) ? FIXED : $signed({1'b0, cen_r}) - HALF;
    assign calc_sc = (row_empty | col_empty) ? FIXED : $signed({1'b0, cen_c}) - HALF;

    // Pixel 0 is emitted in CALC, before the offsets are registered
    assign off_r = (state_q == CALC) ? calc_sr : sr_q;
    assign off_c = (state_q == CALC) ? calc_sc : sc_q;

    assign sy = $signed({2'b00, r_q}) + $signed({off_r[5], off_r});
    assign sx = $signed({2'b00, c_q}) + $signed({off_c[5], off_c});

    assign in_bounds = !sy[6] && (sy < CW_S) && !sx[6] && (sx < CW_S);
    assign src_idx   = in_bounds ? (AW'(sy[4:0]) * AW'(CANVAS_W) + AW'(sx[4:0])) : '0;
    assign hit       = in_bounds && snap_q[src_idx];

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        rowocc_d = rowocc_q;
        colocc_d = colocc_q;
        row_d    = row_q;
        sr_d     = sr_q;
        sc_d     = sc_q;
        r_d      = r_q;
        c_d      = c_q;
        gap_d    = gap_q;
        last_d   = last_q;
        pix_d    = pixel_o;
        valid_d  = 1'b0;
        busy_d   = o_busy;
        done_d   = 1'b0;
        emit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    snap_d   = i_handwrite;
                    rowocc_d = '0;
                    colocc_d = '0;
                    row_d    = '0;
                    r_d      = '0;
                    c_d      = '0;
                    gap_d    = '0;
                    last_d   = 1'b0;
                    busy_d   = 1'b1;
                    if (CENTER) begin
                        state_d = SCAN;
                    end else begin
                        sr_d    = FIXED;
                        sc_d    = FIXED;
                        state_d = STREAM;
                    end
                end
            end
            SCAN: begin
                rowocc_d[row_q] = |row_bits;
                colocc_d        = colocc_q | row_bits;
                row_d           = row_q + 5'd1;
                if (row_q == LAST_ROW) state_d = CALC;
            end
            CALC: begin
                sr_d    = calc_sr;
                sc_d    = calc_sc;
                emit    = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (last_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else begin
                    emit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            pix_d   = hit ? PIXEL_ON : 8'd0;
            valid_d = 1'b1;
            gap_d   = GAP_V;
            if (c_q == LAST_OUT) begin
                c_d = '0;
                if (r_q == LAST_OUT) last_d = 1'b1;
                else                 r_d    = r_q + 5'd1;
            end else begin
                c_d = c_q + 5'd1;
            end
        end
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            snap_q        <= '0;
            rowocc_q      <= '0;
            colocc_q      <= '0;
            row_q         <= '0;
            sr_q          <= '0;
            sc_q          <= '0;
            r_q           <= '0;
            c_q           <= '0;
            gap_q         <= '0;
            last_q        <= 1'b0;
            pixel_o       <= 8'd0;
            pixel_o_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            rowocc_q      <= rowocc_d;
            colocc_q      <= colocc_d;
            row_q         <= row_d;
            sr_q          <= sr_d;
            sc_q          <= sc_d;
            r_q           <= r_d;
            c_q           <= c_d;
            gap_q         <= gap_d;
            last_q        <= last_d;
            pixel_o       <= pix_d;
            pixel_o_valid <= valid_d;
            o_busy        <= busy_d;
            o_done        <= done_d;
        end
    end

endmodule

// File: tb/tb_handwrite_streamer.sv
// Scoreboard bench: three streamer instances (centred, fixed crop,
// fixed crop with GAP=3) driven one at a time from a shared canvas.
module tb_handwrite_streamer;

    localparam int CW   = 30;
    localparam int OW   = 28;
    localparam int NPIX = OW * OW;

    logic             clk = 1'b0;
    logic             rst;
    logic [CW*CW-1:0] canvas;
    logic             start [3];
    logic [7:0]       pix   [3];
    logic             vld   [3];
    logic             busy  [3];
    logic             done  [3];

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q [$];

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    handwrite_streamer #(.CENTER(1'b1), .GAP(0)) u_c1 (
        .clk(clk), .rst(rst), .i_handwrite(canvas), .i_start(start[0]),
        .pixel_o(pix[0]), .pixel_o_valid(vld[0]), .o_busy(busy[0]), .o_done(done[0]));

    handwrite_streamer #(.CENTER(1'b0), .GAP(0)) u_c0 (
        .clk(clk), .rst(rst), .i_handwrite(canvas), .i_start(start[1]),
        .pixel_o(pix[1]), .pixel_o_valid(vld[1]), .o_busy(busy[1]), .o_done(done[1]));

    handwrite_streamer #(.CENTER(1'b0), .GAP(3)) u_g3 (
        .clk(clk), .rst(rst), .i_handwrite(canvas), .i_start(start[2]),
        .pixel_o(pix[2]), .pixel_o_valid(vld[2]), .o_busy(busy[2]), .o_done(done[2]));

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    endtask

    // Reference image: bounding-box centre minus OUT_W/2, or offset 1 when
    // not centring or when the canvas is blank
    function automatic void push_exp(input logic [CW*CW-1:0] cv, input bit ctr);
        int minr = CW, maxr = -1, minc = CW, maxc = -1;
        int sr = 1, sc = 1, sy, sx;
        for (int y = 0; y < CW; y++)
            for (int x = 0; x < CW; x++)
                if (cv[y*CW + x]) begin
                    if (y < minr) minr = y;
                    if (y > maxr) maxr = y;
                    if (x < minc) minc = x;
                    if (x > maxc) maxc = x;
                end
        if (ctr && maxr >= 0) begin
            sr = (minr + maxr) / 2 - OW / 2;
            sc = (minc + maxc) / 2 - OW / 2;
        end
        for (int r = 0; r < OW; r++)
            for (int c = 0; c < OW; c++) begin
                sy = r + sr;
                sx = c + sc;
                if (sy >= 0 && sy < CW && sx >= 0 && sx < CW && cv[sy*CW + sx])
                    exp_q.push_back(8'd255);
                else
                    exp_q.push_back(8'd0);
            end
    endfunction

    // Every valid pixel from any instance is compared against the queue head
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (vld[d]) begin
                if (exp_q.size() == 0) chk("extra_pixel", 1, 0);
                else                   chk("pixel", int'(pix[d]), int'(exp_q.pop_front()));
            end
        end
    end

    // mode 0: plain frame; 1: re-start and canvas change at pixel 200;
    // 2: reset at pixel 100.  Returns in the o_done cycle for modes 0/1.
    task automatic run(input int d, input bit ctr, input int lat, input int spacing, input int mode);
        int s_cyc, nv = 0, first = -1, last = -1, done_at = -1, bad_space = 0, busy_done = 1, stray = 0;
        bit pend = 0;
        push_exp(canvas, ctr);
        start[d] = 1'b1;
        s_cyc = cyc;
        @(negedge clk); #1;
        start[d] = 1'b0;
        for (int t = 0; t < 5000 && done_at < 0; t++) begin
            @(negedge clk); #1;
            if (pend) begin
                start[d] = 1'b0;
                pend = 0;
            end
            if (vld[d]) begin
                if (nv == 0) first = cyc;
                else if (cyc - last != spacing) bad_space++;
                last = cyc;
                nv++;
                if (mode == 1 && nv == 200) begin
                    start[d] = 1'b1;
                    pend = 1;
                    canvas = ~canvas;
                end
                if (mode == 2 && nv == 100) begin
                    rst = 1'b1;
                    @(negedge clk); #1;
                    rst = 1'b0;
                    chk("rst_valid", int'(vld[d]), 0);
                    chk("rst_busy", int'(busy[d]), 0);
                    chk("rst_done", int'(done[d]), 0);
                    exp_q.delete();
                    repeat (40) begin
                        @(negedge clk); #1;
                        if (vld[d] || done[d] || busy[d]) stray++;
                    end
                    chk("rst_quiet", stray, 0);
                    return;
                end
            end
            if (done[d]) begin
                done_at = cyc;
                busy_done = int'(busy[d]);
            end
        end
        chk("done_seen", int'(done_at >= 0), 1);
        chk("first_latency", first - s_cyc, lat);
        chk("pixel_count", nv, NPIX);
        chk("done_after_last", done_at - last, 1);
        chk("spacing", bad_space, 0);
        chk("busy_at_done", busy_done, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic quiet(input int d, input int n);
        int stray = 0;
        repeat (n) begin
            @(negedge clk); #1;
            if (vld[d] || done[d] || busy[d]) stray++;
        end
        chk("quiet", stray, 0);
    endtask

    initial begin
        rst = 1'b1;
        canvas = '0;
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_pixel", int'(pix[d]), 0);
            chk("reset_valid", int'(vld[d]), 0);
            chk("reset_busy", int'(busy[d]), 0);
            chk("reset_done", int'(done[d]), 0);
        end
        rst = 1'b0;
        @(negedge clk); #1;

        // Blank canvas, centred
        canvas = '0;
        run(0, 1'b1, 32, 1, 0);
        quiet(0, 5);

        // Dot at the top-left corner lands on pixel 406
        canvas = '0;
        canvas[0] = 1'b1;
        run(0, 1'b1, 32, 1, 0);
        quiet(0, 5);

        // Dot at the bottom-right corner, centred then fixed crop
        canvas = '0;
        canvas[CW*CW-1] = 1'b1;
        run(0, 1'b1, 32, 1, 0);
        quiet(0, 5);
        run(1, 1'b0, 2, 1, 0);
        quiet(1, 5);

        // Full canvas, fixed crop, without and with the gap
        canvas = '1;
        run(1, 1'b0, 2, 1, 0);
        quiet(1, 5);
        run(2, 1'b0, 2, 4, 0);
        quiet(2, 5);

        // Off-centre rectangle
        canvas = '0;
        for (int y = 3; y <= 12; y++)
            for (int x = 17; x <= 25; x++)
                canvas[y*CW + x] = 1'b1;
        run(0, 1'b1, 32, 1, 0);
        quiet(0, 5);

        // Random sparse canvases
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < CW*CW; i++) canvas[i] = ($urandom_range(0, 7) == 0);
            run(0, 1'b1, 32, 1, 0);
            quiet(0, 5);
        end
        run(2, 1'b0, 2, 4, 0);
        quiet(2, 5);

        // Start while busy is ignored and the snapshot is isolated
        canvas = '0;
        for (int y = 20; y <= 28; y++) canvas[y*CW + 4] = 1'b1;
        run(0, 1'b1, 32, 1, 1);
        quiet(0, 40);

        // Start in the o_done cycle begins the next frame
        run(1, 1'b0, 2, 1, 0);
        run(1, 1'b0, 2, 1, 0);
        quiet(1, 5);

        // Reset mid-frame, then a clean frame
        canvas = '1;
        run(0, 1'b1, 32, 1, 2);
        run(0, 1'b1, 32, 1, 0);
        quiet(0, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
